// File: rtl/apb_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_cmd_master_if
// Description : Bundle of the command, response and APB bus signals around
//               apb_cmd_master.
//               master modport : view taken by apb_cmd_master
//               slave  modport : view taken by whoever drives commands,
//                                consumes responses and models the APB slave
//               Command  : cmd_valid, cmd_ready, cmd_write, cmd_addr, cmd_wdata
//               Response : rsp_valid, rsp_ready, rsp_rdata, rsp_err, rsp_timeout
//               Status   : busy
//               APB      : psel, penable, pwrite, paddr, pwdata, prdata,
//                          pready, pslverr
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_cmd_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  busy;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_cmd_master
// Description : Single-outstanding APB3 requester. Turns a valid/ready
//               command into one SETUP/ACCESS transfer and returns exactly
//               one response per accepted command. Slave wait states are
//               honoured; an optional watchdog aborts transfers the slave
//               never completes (TIMEOUT_CYCLES = 0 disables it).
// Ports       : pclk   - clock, rising edge
//               preset - synchronous active-high reset
//               bus    - apb_cmd_master_if.master (command, response,
//                        busy status and APB requester signals)
// Revision    : 1.0 - initial release
// ============================================================================
module apb_cmd_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    apb_cmd_master_if.master        bus
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;

    localparam int c_WD_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_MAX = {c_WD_W{1'b1}};

    logic [1:0]            r_state;
    logic [c_WD_W-1:0]     r_wd;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    logic                  w_cmd_ready;
    logic                  w_wd_expire;

    // Watchdog fires on the ACCESS cycle that would be the TIMEOUT_CYCLES-th
    // one without pready; with the watchdog disabled it never fires.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);
            assign w_wd_expire = (r_wd == c_WD_LAST);
        end else begin : g_no_wdog
            assign w_wd_expire = 1'b0;
        end
    endgenerate

    // Ready is gated by reset directly so nothing can be handed over while
    // the block is being reset.
    assign w_cmd_ready = (r_state == c_ST_IDLE) && !preset;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state       <= c_ST_IDLE;
            r_wd          <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_pwrite <= bus.cmd_write;
                        r_paddr  <= bus.cmd_addr;
                        r_pwdata <= bus.cmd_wdata;
                        r_psel   <= 1'b1;
                        r_state  <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_wd      <= '0;
                    r_state   <= c_ST_ACCESS;
                end
                c_ST_ACCESS: begin
                    // Completion has priority over a watchdog abort in the
                    // same cycle; pslverr only matters alongside pready.
                    if (bus.pready) begin
                        r_rsp_rdata   <= r_pwrite ? '0 : bus.prdata;
                        r_rsp_err     <= bus.pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= c_ST_RESP;
                    end else if (w_wd_expire) begin
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= c_ST_RESP;
                    end else if (r_wd != c_WD_MAX) begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                c_ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.busy        = (r_state != c_ST_IDLE);
    assign bus.psel        = r_psel;
    assign bus.penable     = r_penable;
    assign bus.pwrite      = r_pwrite;
    assign bus.paddr       = r_paddr;
    assign bus.pwdata      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_cmd_master
// Description : Self-checking bench for apb_cmd_master (TIMEOUT_CYCLES = 4).
//               Plays the command source, response sink and a RAM-like APB
//               slave with a per-transfer wait-state count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_cmd_master;

    localparam int c_AW = 8;
    localparam int c_DW = 32;
    localparam int c_TO = 4;

    logic pclk;
    logic preset;

    apb_cmd_master_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) bus ();

    apb_cmd_master #(
        .ADDR_WIDTH     (c_AW),
        .DATA_WIDTH     (c_DW),
        .TIMEOUT_CYCLES (c_TO)
    ) u_dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] slv_mem [256];  // memory behind the APB slave, written via the bus
    logic [31:0] ref_mem [256];  // expected memory contents from the model

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          waits;
        logic        slverr;
        int          hold;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_to;
        int          e_acc;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer-level reference: a transfer with fewer wait states than the
    // watchdog limit completes after waits+1 ACCESS cycles; otherwise it is
    // aborted after exactly c_TO ACCESS cycles. Only clean completed writes
    // change memory.
    task automatic model(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                         input int waits, input logic slverr,
                         output logic [31:0] e_rdata, output logic e_err,
                         output logic e_to, output int e_acc);
        logic timed_out;
        timed_out = (waits >= c_TO);
        e_acc     = timed_out ? c_TO : waits + 1;
        e_to      = timed_out;
        e_err     = timed_out ? 1'b1 : slverr;
        e_rdata   = (timed_out || wr) ? 32'h0 : ref_mem[addr];
        if (!timed_out && wr && !slverr) ref_mem[addr] = wdata;
    endtask

    // Issue one command starting right after a clock edge with the DUT idle.
    task automatic run_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                           input int waits, input logic slverr, input int hold,
                           input logic [31:0] e_rdata, input logic e_err,
                           input logic e_to, input int e_acc);
        int n_acc;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        #1;
        chk("cmd_ready_idle", {31'b0, bus.cmd_ready}, 32'd1);
        @(posedge pclk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 8'($urandom);
        bus.cmd_wdata = $urandom;
        chk("setup_psel",    {31'b0, bus.psel},      32'd1);
        chk("setup_penable", {31'b0, bus.penable},   32'd0);
        chk("setup_paddr",   {24'b0, bus.paddr},     {24'b0, addr});
        chk("setup_pwrite",  {31'b0, bus.pwrite},    {31'b0, wr});
        chk("setup_pwdata",  bus.pwdata,             wdata);
        chk("setup_cmd_rdy", {31'b0, bus.cmd_ready}, 32'd0);
        @(posedge pclk); #1;
        n_acc = 0;
        for (int k = 0; k < 20; k++) begin
            if (!(bus.psel && bus.penable)) break;
            n_acc++;
            chk("access_paddr",  {24'b0, bus.paddr},  {24'b0, addr});
            chk("access_pwrite", {31'b0, bus.pwrite}, {31'b0, wr});
            chk("access_busy",   {31'b0, bus.busy},   32'd1);
            bus.pready = (k == waits);
            if (bus.pready) begin
                bus.pslverr = slverr;
                bus.prdata  = slv_mem[bus.paddr];
                if (bus.pwrite && !slverr) slv_mem[bus.paddr] = bus.pwdata;
            end else begin
                bus.pslverr = 1'($urandom);
                bus.prdata  = $urandom;
            end
            @(posedge pclk); #1;
        end
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        chk("access_cycles", n_acc, e_acc);
        chk("rsp_valid",     {31'b0, bus.rsp_valid},   32'd1);
        chk("rsp_psel_low",  {31'b0, bus.psel},        32'd0);
        chk("rsp_pen_low",   {31'b0, bus.penable},     32'd0);
        chk("rsp_rdata",     bus.rsp_rdata,            e_rdata);
        chk("rsp_err",       {31'b0, bus.rsp_err},     {31'b0, e_err});
        chk("rsp_timeout",   {31'b0, bus.rsp_timeout}, {31'b0, e_to});
        for (int h = 0; h < hold; h++) begin
            bus.cmd_valid = 1'b1;
            @(posedge pclk); #1;
            chk("bp_cmd_ready", {31'b0, bus.cmd_ready},   32'd0);
            chk("bp_rsp_valid", {31'b0, bus.rsp_valid},   32'd1);
            chk("bp_rdata",     bus.rsp_rdata,            e_rdata);
            chk("bp_err",       {31'b0, bus.rsp_err},     {31'b0, e_err});
            chk("bp_timeout",   {31'b0, bus.rsp_timeout}, {31'b0, e_to});
        end
        bus.rsp_ready = 1'b1;
        @(posedge pclk); #1;
        bus.rsp_ready = 1'b0;
        chk("post_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("post_busy",      {31'b0, bus.busy},      32'd0);
        chk("post_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] r_d;
        logic        r_e, r_t;
        int          r_a;
        logic        v_wr, v_err;
        logic [7:0]  v_addr;
        logic [31:0] v_wdata;
        int          v_waits, v_hold;

        for (int i = 0; i < 256; i++) begin
            slv_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end

        //            wr    addr   wdata         waits err  hold  e_rdata       e_err e_to  e_acc
        vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 0,    1'b0, 0,   32'h0,        1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 8'h10, 32'h0,        2,    1'b0, 0,   32'hDEADBEEF, 1'b0, 1'b0, 3};
        vecs[2] = '{1'b1, 8'h20, 32'h00001234, 0,    1'b0, 0,   32'h0,        1'b0, 1'b0, 1};
        vecs[3] = '{1'b0, 8'h20, 32'h0,        0,    1'b1, 0,   32'h00001234, 1'b1, 1'b0, 1};
        vecs[4] = '{1'b0, 8'h10, 32'h0,        9,    1'b0, 0,   32'h0,        1'b1, 1'b1, 4};
        vecs[5] = '{1'b0, 8'h10, 32'h0,        3,    1'b0, 0,   32'hDEADBEEF, 1'b0, 1'b0, 4};
        vecs[6] = '{1'b1, 8'h30, 32'hCAFEF00D, 1,    1'b0, 5,   32'h0,        1'b0, 1'b0, 2};
        vecs[7] = '{1'b0, 8'h30, 32'h0,        0,    1'b0, 0,   32'hCAFEF00D, 1'b0, 1'b0, 1};
        vecs[8] = '{1'b1, 8'h40, 32'h55AA55AA, 6,    1'b0, 0,   32'h0,        1'b1, 1'b1, 4};
        vecs[9] = '{1'b0, 8'h40, 32'h0,        1,    1'b0, 0,   32'h0,        1'b0, 1'b0, 2};

        preset        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        bus.cmd_valid = 1'b1;
        #1;
        chk("rst_cmd_ready",   {31'b0, bus.cmd_ready},   32'd0);
        chk("rst_busy",        {31'b0, bus.busy},        32'd0);
        chk("rst_psel",        {31'b0, bus.psel},        32'd0);
        chk("rst_penable",     {31'b0, bus.penable},     32'd0);
        chk("rst_pwrite",      {31'b0, bus.pwrite},      32'd0);
        chk("rst_paddr",       {24'b0, bus.paddr},       32'd0);
        chk("rst_pwdata",      bus.pwdata,               32'd0);
        chk("rst_rsp_valid",   {31'b0, bus.rsp_valid},   32'd0);
        chk("rst_rsp_rdata",   bus.rsp_rdata,            32'd0);
        chk("rst_rsp_err",     {31'b0, bus.rsp_err},     32'd0);
        chk("rst_rsp_timeout", {31'b0, bus.rsp_timeout}, 32'd0);
        @(posedge pclk); #1;
        chk("rst_held_psel", {31'b0, bus.psel}, 32'd0);
        bus.cmd_valid = 1'b0;
        preset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            model(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].slverr,
                  r_d, r_e, r_t, r_a);
            run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].slverr,
                    vecs[i].hold, vecs[i].e_rdata, vecs[i].e_err, vecs[i].e_to, vecs[i].e_acc);
        end
        bus.cmd_valid = 1'b0;

        // Reset during a wait-stated write: the transfer is dropped silently.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 8'h50;
        bus.cmd_wdata = 32'h11111111;
        @(posedge pclk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge pclk); #1;
        chk("mid_access_pen", {31'b0, bus.penable}, 32'd1);
        bus.pready = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
        @(posedge pclk); #1;
        preset = 1'b0;
        chk("mid_rst_psel",      {31'b0, bus.psel},      32'd0);
        chk("mid_rst_penable",   {31'b0, bus.penable},   32'd0);
        chk("mid_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("mid_rst_busy",      {31'b0, bus.busy},      32'd0);
        chk("mid_rst_paddr",     {24'b0, bus.paddr},     32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            chk("mid_rst_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        end
        model(1'b0, 8'h50, 32'h0, 0, 1'b0, r_d, r_e, r_t, r_a);
        run_cmd(1'b0, 8'h50, 32'h0, 0, 1'b0, 0, r_d, r_e, r_t, r_a);

        // Randomised transfers against the transfer-level model.
        for (int i = 0; i < 40; i++) begin
            v_wr    = 1'($urandom);
            v_addr  = 8'($urandom_range(0, 15));
            v_wdata = $urandom;
            v_waits = $urandom_range(0, 5);
            v_err   = ($urandom_range(0, 3) == 0);
            v_hold  = $urandom_range(0, 2);
            model(v_wr, v_addr, v_wdata, v_waits, v_err, r_d, r_e, r_t, r_a);
            run_cmd(v_wr, v_addr, v_wdata, v_waits, v_err, v_hold, r_d, r_e, r_t, r_a);
        end
        bus.cmd_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
